operand_fetch_seq: RTL

Operand fetch sequencer for the systolic operand path: accepts one tile command and walks the K dimension, issuing one SRAM read address per cycle. It drives the head of the 8-unit A or B operand skew chain with `rdaddr`, `en`, `cmen` and a held `addrtype`. Two instances are used, one per operand. The SRAM read (1-cycle latency) lands aligned with the chain's internally registered address.

---
 rtl/operand_fetch_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: walks the K dimension of one tile command, issuing one SRAM read address per cycle to the operand skew chain.
package params;
  typedef enum logic [1:0] {FP16 = 2'd0, INT8 = 2'd1, INT4 = 2'd2} datatype;
  typedef struct packed {
    datatype dt;
    logic [1:0] rc;
  } addrgen_t;
endpackage

module operand_fetch_seq #(
  parameter int CHAIN_DEPTH = 8,
  parameter int K_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  params::datatype  cmd_datatype,
  input  logic [1:0]       cmd_rc,
  input  logic [31:0]      cmd_base,
  input  logic [K_W-1:0]   cmd_ksteps,
  input  logic             stall,
  output logic [31:0]      rdaddr,
  output logic             sram_rd,
  output logic             en,
  output logic             cmen,
  output params::addrgen_t addrtype,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int D_W = CHAIN_DEPTH > 1 ? $clog2(CHAIN_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state;
  logic [31:0] addr;
  logic [K_W-1:0] kcnt, ksteps;
  logic [D_W-1:0] dcnt;
  logic [2:0] stride, cmd_stride;
  assign cmd_stride = (cmd_datatype == params::FP16 || (cmd_datatype == params::INT8 && cmd_rc != 2'b00)) ? 3'd2 : 3'd4;
  assign sram_rd = en;
  // The first step issues on the acceptance edge, so addr always holds the next address to read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdaddr <= '0;
      en <= 1'b0;
      cmen <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      ready <= 1'b1;
      addrtype <= params::addrgen_t'{params::FP16, 2'b00};
      addr <= '0;
      kcnt <= '0;
      ksteps <= '0;
      dcnt <= '0;
      stride <= '0;
    end else begin
      en <= 1'b0;
      cmen <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (cmd_rc == 2'b11) err <= 1'b1;
          else begin
            addrtype <= params::addrgen_t'{cmd_datatype, cmd_rc};
            stride <= cmd_stride;
            ksteps <= cmd_ksteps;
            ready <= 1'b0;
            busy <= 1'b1;
            if (cmd_ksteps == '0) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= FETCH;
              en <= 1'b1;
              rdaddr <= cmd_base;
              cmen <= cmd_ksteps == K_W'(1);
              addr <= cmd_base + 32'(cmd_stride);
              kcnt <= K_W'(1);
            end
          end
        end
        FETCH: if (kcnt == ksteps) begin
          state <= DRAIN;
          dcnt <= '0;
        end else if (!stall) begin
          en <= 1'b1;
          rdaddr <= addr;
          cmen <= kcnt == ksteps - K_W'(1);
          addr <= addr + 32'(stride);
          kcnt <= kcnt + K_W'(1);
        end
        DRAIN: if (dcnt == D_W'(CHAIN_DEPTH - 1)) begin
          state <= DONE;
          done <= 1'b1;
        end else dcnt <= dcnt + D_W'(1);
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
